// File: rtl/axi4_lite_master.sv
// axi4_lite_master
//
// AXI4-Lite initiator that turns single user commands into one AXI4-Lite
// read or write burst at a time. A command is accepted in IDLE. The master
// then runs either the AW/W/B channels or the AR/R channels. It returns the
// captured read data and response with a one-cycle done pulse.
//
// Ports:
//   ACLK, ARESET             clock (rising edge) and asynchronous active-high reset
//   cmd_valid / cmd_ready    user command handshake; cmd_ready is high only in IDLE
//   cmd_write                1 = write, 0 = read
//   cmd_addr, cmd_wdata      command address and write data
//   done                     one-cycle completion pulse
//   rdata                    last captured read data; writes leave it unchanged
//   resp                     BRESP/RRESP of the most recent transaction
//   AW*, W*, B*              write address, write data and write response channels
//   AR*, R*                  read address and read data channels

module axi4_lite_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [1:0]            RRESP
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   b_done;
  logic   ar_done;
  logic   r_done;

  logic   aw_hs;
  logic   w_hs;
  logic   b_hs;
  logic   ar_hs;
  logic   r_hs;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID  & WREADY;
  assign b_hs  = BVALID  & BREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID  & RREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      rdata     <= '0;
      resp      <= 2'b00;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      b_done    <= 1'b0;
      ar_done   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              AWADDR  <= cmd_addr;
              WDATA   <= cmd_wdata;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              // The slave pulses BVALID for a single cycle without waiting,
              // so BREADY is held for the whole write.
              BREADY  <= 1'b1;
              state   <= WRITE;
            end else begin
              ARADDR  <= cmd_addr;
              ARVALID <= 1'b1;
              // RREADY goes up together with ARVALID because the slave may
              // return R in the same cycle it accepts AR.
              RREADY  <= 1'b1;
              state   <= READ;
            end
          end
        end

        WRITE: begin
          if (aw_hs) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            WVALID <= 1'b0;
            w_done <= 1'b1;
          end
          if (b_hs) begin
            b_done <= 1'b1;
            resp   <= BRESP;
          end
          // Handshakes that happen on this edge count toward completion.
          if ((aw_done | aw_hs) & (w_done | w_hs) & (b_done | b_hs)) begin
            BREADY <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end

        READ: begin
          if (ar_hs) begin
            ARVALID <= 1'b0;
            ar_done <= 1'b1;
          end
          if (r_hs) begin
            r_done <= 1'b1;
            rdata  <= RDATA;
            resp   <= RRESP;
          end
          if ((ar_done | ar_hs) & (r_done | r_hs)) begin
            RREADY <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          done      <= 1'b0;
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
          b_done    <= 1'b0;
          ar_done   <= 1'b0;
          r_done    <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master
//
// Testbench for axi4_lite_master. It contains a configurable AXI4-Lite
// slave with programmable ready delays, a same-cycle R option, forced
// response codes and one-cycle BVALID pulses. Each expected completion
// is queued when its command is accepted and compared on done.

module tb_axi4_lite_master;

  logic        ACLK;
  logic        ARESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  resp;
  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic [1:0]  RRESP;

  axi4_lite_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .done(done), .rdata(rdata), .resp(resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expVal);
    checkCount++;
    if (got === expVal) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, expVal);
  endtask

  // Slave configuration, set by the stimulus between transactions.
  int          cfg_aw_delay = 0;
  int          cfg_w_delay  = 0;
  int          cfg_ar_delay = 0;
  bit          cfg_rsame    = 0;
  bit          cfg_rovr     = 0;
  logic [31:0] cfg_rdata    = '0;
  logic [1:0]  cfg_bresp    = 2'b00;
  logic [1:0]  cfg_rresp    = 2'b00;

  // Slave state.
  logic [31:0] s_regs [4];
  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_got, w_got, r_pend;
  logic [3:0]  aw_q;
  logic [31:0] w_q, r_q;
  logic [1:0]  rresp_q;
  logic [31:0] s_rd_val;
  int          aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0, r_hs_cnt = 0;
  int          b_miss = 0;

  assign AWREADY  = AWVALID && (aw_cnt >= cfg_aw_delay);
  assign WREADY   = WVALID && (w_cnt >= cfg_w_delay);
  assign ARREADY  = ARVALID && (ar_cnt >= cfg_ar_delay) && !r_pend;
  assign s_rd_val = cfg_rovr ? cfg_rdata : s_regs[ARADDR[3:2]];
  assign RVALID   = r_pend || (cfg_rsame && ARVALID && ARREADY);
  assign RDATA    = r_pend ? r_q : s_rd_val;
  assign RRESP    = r_pend ? rresp_q : cfg_rresp;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_cnt  <= 0;
      w_cnt   <= 0;
      ar_cnt  <= 0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      r_pend  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= 2'b00;
      aw_q    <= '0;
      w_q     <= '0;
      r_q     <= '0;
      rresp_q <= 2'b00;
    end else begin
      if (AWVALID && AWREADY) begin
        aw_got    <= 1'b1;
        aw_q      <= AWADDR;
        aw_cnt    <= 0;
        aw_hs_cnt <= aw_hs_cnt + 1;
      end else if (AWVALID) aw_cnt <= aw_cnt + 1;
      if (WVALID && WREADY) begin
        w_got    <= 1'b1;
        w_q      <= WDATA;
        w_cnt    <= 0;
        w_hs_cnt <= w_hs_cnt + 1;
      end else if (WVALID) w_cnt <= w_cnt + 1;
      BVALID <= 1'b0;
      if (BVALID && BREADY) b_hs_cnt <= b_hs_cnt + 1;
      if (BVALID && !BREADY) b_miss <= b_miss + 1;
      if (aw_got && w_got && !BVALID) begin
        BVALID             <= 1'b1;
        BRESP              <= cfg_bresp;
        s_regs[aw_q[3:2]]  <= w_q;
        aw_got             <= 1'b0;
        w_got              <= 1'b0;
      end
      if (ARVALID && ARREADY) begin
        ar_cnt    <= 0;
        ar_hs_cnt <= ar_hs_cnt + 1;
        if (!cfg_rsame) begin
          r_pend  <= 1'b1;
          r_q     <= s_rd_val;
          rresp_q <= cfg_rresp;
        end
      end else if (ARVALID) ar_cnt <= ar_cnt + 1;
      if (RVALID && RREADY) begin
        r_hs_cnt <= r_hs_cnt + 1;
        r_pend   <= 1'b0;
      end
    end
  end

  // Scoreboard and reference register model.
  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model_regs [4];
  logic [31:0] last_rdata = '0;
  logic [3:0]  cur_addr   = '0;
  logic [31:0] cur_wdata  = '0;
  int          wr_done_cnt = 0, rd_done_cnt = 0;
  int          w_early = 0, aw_early = 0;

  // Bus stability, completion scoreboard and channel-ordering counters.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (AWVALID) checkOutput("awaddr_stable", {28'd0, AWADDR}, {28'd0, cur_addr});
      if (WVALID)  checkOutput("wdata_stable", WDATA, cur_wdata);
      if (ARVALID) checkOutput("araddr_stable", {28'd0, ARADDR}, {28'd0, cur_addr});
      if (AWVALID && !WVALID) w_early++;
      if (WVALID && !AWVALID) aw_early++;
      if (done) begin
        if (sb.size() == 0) checkOutput("unexpected_done", 32'd1, 32'd0);
        else begin
          mon_e = sb.pop_front();
          checkOutput(mon_e.wr ? "wr_rdata" : "rd_rdata", rdata, mon_e.rdata);
          checkOutput(mon_e.wr ? "wr_resp" : "rd_resp", {30'd0, resp}, {30'd0, mon_e.resp});
          if (mon_e.wr) begin
            model_regs[mon_e.addr[3:2]] = mon_e.wdata;
            wr_done_cnt++;
            checkOutput("b_before_done", b_hs_cnt, wr_done_cnt);
          end else begin
            rd_done_cnt++;
            checkOutput("r_before_done", r_hs_cnt, rd_done_cnt);
          end
        end
      end
    end
  end

  // Present one command and hold it until accepted; with hold set, cmd_valid
  // stays high so the next call can present a new command back to back.
  task automatic applyStimulus(input logic wr, input logic [3:0] addr, input logic [31:0] data, input bit hold);
    exp_t e;
    bit   ok = 0;
    @(negedge ACLK);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready) begin
        checkOutput("single_outstanding", sb.size(), 32'd0);
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = data;
        if (wr) begin
          e.rdata = last_rdata;
          e.resp  = cfg_bresp;
        end else begin
          e.rdata    = cfg_rovr ? cfg_rdata : model_regs[addr[3:2]];
          e.resp     = cfg_rresp;
          last_rdata = e.rdata;
        end
        sb.push_back(e);
        cur_addr  = addr;
        cur_wdata = data;
        ok = 1;
        break;
      end
      @(negedge ACLK);
    end
    if (!ok) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge ACLK);
      if (!hold) begin
        @(negedge ACLK);
        cmd_valid = 1'b0;
      end
    end
  endtask

  task automatic waitIdle();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge ACLK);
      #1;
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("done_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  int aw0, w0, b0, ar0, r0, we0, ae0;

  initial begin
    ARESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_valids", {27'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 32'd0);
    checkOutput("rst_addr", {24'd0, AWADDR, ARADDR}, 32'd0);
    checkOutput("rst_wdata", WDATA, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_resp", {30'd0, resp}, 32'd0);

    // Single write then read back, one handshake per channel each.
    aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt; ar0 = ar_hs_cnt; r0 = r_hs_cnt;
    applyStimulus(1'b1, 4'h4, 32'hDEADBEEF, 0);
    waitIdle();
    applyStimulus(1'b0, 4'h4, 32'h0, 0);
    waitIdle();
    checkOutput("aw_hs_count", aw_hs_cnt - aw0, 32'd1);
    checkOutput("w_hs_count", w_hs_cnt - w0, 32'd1);
    checkOutput("b_hs_count", b_hs_cnt - b0, 32'd1);
    checkOutput("ar_hs_count", ar_hs_cnt - ar0, 32'd1);
    checkOutput("r_hs_count", r_hs_cnt - r0, 32'd1);

    // All four registers.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'(i * 4), 32'(8'h11 * (i + 1)), 0);
      waitIdle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'(i * 4), 32'h0, 0);
      waitIdle();
    end

    // AW delayed, W immediate: WVALID drops while AWVALID is held 5 cycles.
    cfg_aw_delay = 5;
    we0 = w_early;
    applyStimulus(1'b1, 4'hC, 32'hA5A5A5A5, 0);
    waitIdle();
    checkOutput("w_drops_first", w_early - we0, 32'd5);
    cfg_aw_delay = 0;

    // Swapped, with a non-OKAY BRESP passed through.
    cfg_w_delay = 5;
    cfg_bresp   = 2'b11;
    ae0 = aw_early;
    applyStimulus(1'b1, 4'h8, 32'h5A5A5A5A, 0);
    waitIdle();
    checkOutput("aw_drops_first", aw_early - ae0, 32'd5);
    cfg_w_delay = 0;
    cfg_bresp   = 2'b00;
    applyStimulus(1'b0, 4'h8, 32'h0, 0);
    waitIdle();

    // R returned in the same cycle as ARREADY with SLVERR.
    cfg_rsame    = 1;
    cfg_ar_delay = 2;
    cfg_rovr     = 1;
    cfg_rdata    = 32'hCAFE0000;
    cfg_rresp    = 2'b10;
    applyStimulus(1'b0, 4'h0, 32'h0, 0);
    waitIdle();
    cfg_rsame    = 0;
    cfg_ar_delay = 0;
    cfg_rovr     = 0;
    cfg_rresp    = 2'b00;
    applyStimulus(1'b1, 4'h0, 32'h0BADF00D, 0);
    waitIdle();

    // cmd_valid held across a busy write with a different command behind it.
    cfg_aw_delay = 3;
    applyStimulus(1'b1, 4'h0, 32'h00001234, 1);
    applyStimulus(1'b1, 4'h4, 32'h00005678, 0);
    waitIdle();
    cfg_aw_delay = 0;
    applyStimulus(1'b0, 4'h0, 32'h0, 0);
    waitIdle();
    applyStimulus(1'b0, 4'h4, 32'h0, 0);
    waitIdle();

    // Reset while AWVALID is high.
    cfg_aw_delay = 10;
    applyStimulus(1'b1, 4'h8, 32'h55555555, 0);
    repeat (2) @(negedge ACLK);
    checkOutput("aw_before_reset", {31'd0, AWVALID}, 32'd1);
    #2;
    ARESET = 1'b1;
    #1;
    checkOutput("aw_async_drop", {31'd0, AWVALID}, 32'd0);
    checkOutput("no_done_in_reset", {31'd0, done}, 32'd0);
    sb.delete();
    last_rdata   = '0;
    cfg_aw_delay = 0;
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rdata_cleared", rdata, 32'd0);
    applyStimulus(1'b1, 4'h8, 32'h77777777, 0);
    waitIdle();
    applyStimulus(1'b0, 4'h8, 32'h0, 0);
    waitIdle();

    checkOutput("bvalid_never_missed", b_miss, 32'd0);
    repeat (2) @(negedge ACLK);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
